// File: rtl/isolde_xif_coproc_responder.sv
// ============================================================================
// isolde_xif_coproc_responder
// CV-X-IF coprocessor endpoint with an in-order offload FIFO and a small
// fixed-latency ALU.
// Rev 1.0
// ============================================================================
`default_nettype none

module isolde_xif_coproc_responder #(
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned Latency     = 2,
  parameter logic [6:0]  OpcodeMatch = 7'h0B
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [95:0]        issue_rs_i,
  input  logic [2:0]         issue_rs_valid_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [31:0]        result_data_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o,
  output logic               busy_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = (Latency > 1) ? $clog2(Latency) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;

  // Entry storage; status bits are packed so the commit search is a simple loop
  logic [IdWidth-1:0] id_q  [FifoDepth];
  logic [2:0]         f3_q  [FifoDepth];
  logic [31:0]        rs1_q [FifoDepth];
  logic [31:0]        rs2_q [FifoDepth];
  logic [31:0]        rs3_q [FifoDepth];
  logic [4:0]         rd_q  [FifoDepth];
  logic [FifoDepth-1:0] valid_q, committed_q, killed_q;

  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [2:0]  dec_f3;
  logic [4:0]  dec_rd;
  logic        f3_ok, claimed, need_rs3, ops_ok, full, push, pop, load_res;
  logic        same_id_commit;
  logic [31:0] alu_res;
  logic        unused_instr;

  assign dec_f3       = issue_instr_i[14:12];
  assign dec_rd       = issue_instr_i[11:7];
  assign unused_instr = ^issue_instr_i[31:15];

  always_comb begin
    case (dec_f3)
      3'b000, 3'b001, 3'b010, 3'b100: f3_ok = 1'b1;
      default:                        f3_ok = 1'b0;
    endcase
  end

  assign claimed  = (issue_instr_i[6:0] == OpcodeMatch) && f3_ok;
  assign need_rs3 = claimed && (dec_f3 == 3'b100);
  assign ops_ok   = !claimed ||
                    (issue_rs_valid_i[0] && issue_rs_valid_i[1] &&
                     (!need_rs3 || issue_rs_valid_i[2]));
  assign full     = (count_q == (PtrW+1)'(FifoDepth));

  assign issue_ready_o     = !rst_i && !full && ops_ok;
  assign push              = issue_valid_i && issue_ready_o && claimed;
  assign issue_accept_o    = push;
  assign issue_writeback_o = push && (dec_rd != 5'd0);

  // A commit/kill in the issue cycle for the incoming id lands on the new entry
  assign same_id_commit = commit_valid_i && (commit_id_i == issue_id_i);

  always_comb begin
    case (f3_q[rptr_q])
      3'b000:  alu_res = rs1_q[rptr_q] + rs2_q[rptr_q];
      3'b001:  alu_res = rs1_q[rptr_q] - rs2_q[rptr_q];
      3'b010:  alu_res = rs1_q[rptr_q] ^ rs2_q[rptr_q];
      default: alu_res = rs1_q[rptr_q] + rs2_q[rptr_q] + rs3_q[rptr_q];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    load_res = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_q[rptr_q]) begin
          if (killed_q[rptr_q]) begin
            pop = 1'b1;
          end else if (committed_q[rptr_q]) begin
            state_d = S_EXEC;
            cnt_d   = CntW'(Latency - 1);
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          load_res = 1'b1;
          state_d  = S_RESULT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESULT: begin
        if (result_ready_i) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      committed_q    <= '0;
      killed_q       <= '0;
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_data_o  <= '0;
      result_rd_o    <= '0;
      result_we_o    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      for (int i = 0; i < FifoDepth; i++) begin
        if (commit_valid_i && valid_q[i] && (id_q[i] == commit_id_i)) begin
          if (commit_kill_i) killed_q[i]    <= 1'b1;
          else               committed_q[i] <= 1'b1;
        end
      end

      if (push) begin
        valid_q[wptr_q]     <= 1'b1;
        committed_q[wptr_q] <= same_id_commit && !commit_kill_i;
        killed_q[wptr_q]    <= same_id_commit && commit_kill_i;
        wptr_q              <= wptr_q + 1'b1;
      end

      if (pop) begin
        valid_q[rptr_q] <= 1'b0;
        rptr_q          <= rptr_q + 1'b1;
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (load_res) begin
        result_valid_o <= 1'b1;
        result_id_o    <= id_q[rptr_q];
        result_data_o  <= alu_res;
        result_rd_o    <= rd_q[rptr_q];
        result_we_o    <= (rd_q[rptr_q] != 5'd0);
      end else if ((state_q == S_RESULT) && result_ready_i) begin
        result_valid_o <= 1'b0;
      end
    end
  end

  // Payload needs no reset: it is only read while the matching valid bit is set
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_q[wptr_q]  <= issue_id_i;
      f3_q[wptr_q]  <= dec_f3;
      rs1_q[wptr_q] <= issue_rs_i[31:0];
      rs2_q[wptr_q] <= issue_rs_i[63:32];
      rs3_q[wptr_q] <= issue_rs_i[95:64];
      rd_q[wptr_q]  <= dec_rd;
    end
  end

  assign busy_o = (count_q != '0) || (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_isolde_xif_coproc_responder.sv
// ============================================================================
// tb_isolde_xif_coproc_responder
// Directed self-checking bench for the X-IF coprocessor responder.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_isolde_xif_coproc_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready, issue_accept, issue_wb;
  logic [31:0] issue_instr;
  logic [3:0]  issue_id;
  logic [95:0] issue_rs;
  logic [2:0]  issue_rs_valid;
  logic        commit_valid, commit_kill;
  logic [3:0]  commit_id;
  logic        result_valid, result_ready, result_we, busy;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  isolde_xif_coproc_responder dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .issue_valid_i     (issue_valid),
    .issue_ready_o     (issue_ready),
    .issue_instr_i     (issue_instr),
    .issue_id_i        (issue_id),
    .issue_rs_i        (issue_rs),
    .issue_rs_valid_i  (issue_rs_valid),
    .issue_accept_o    (issue_accept),
    .issue_writeback_o (issue_wb),
    .commit_valid_i    (commit_valid),
    .commit_id_i       (commit_id),
    .commit_kill_i     (commit_kill),
    .result_valid_o    (result_valid),
    .result_ready_i    (result_ready),
    .result_id_o       (result_id),
    .result_data_o     (result_data),
    .result_rd_o       (result_rd),
    .result_we_o       (result_we),
    .busy_o            (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {17'd0, f3, rd, op};
  endfunction

  task automatic do_issue(input string tag, input logic [31:0] instr, input logic [3:0] id,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic exp_acc, input logic exp_wb);
    issue_instr    = instr;
    issue_id       = id;
    issue_rs       = {c, b, a};
    issue_rs_valid = 3'b111;
    issue_valid    = 1'b1;
    #1;
    chk({tag, "_ready"}, 32'(issue_ready), 32'd1);
    chk({tag, "_accept"}, 32'(issue_accept), 32'(exp_acc));
    chk({tag, "_wb"}, 32'(issue_wb), 32'(exp_wb));
    step();
    issue_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
    step();
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [3:0] id, input logic [31:0] data,
                             input logic [4:0] rd, input logic we);
    int n = 0;
    while (!result_valid && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(result_valid), 32'd1);
    chk({tag, "_id"}, 32'(result_id), 32'(id));
    chk({tag, "_data"}, result_data, data);
    chk({tag, "_rd"}, 32'(result_rd), 32'(rd));
    chk({tag, "_we"}, 32'(result_we), 32'(we));
    if (result_ready) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_instr = '0; issue_id = '0; issue_rs = '0;
    issue_rs_valid = 3'b111; commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0;
    result_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst_ready", 32'(issue_ready), 32'd0);
    chk("rst_rvalid", 32'(result_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", result_data, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(issue_ready), 32'd1);

    // Basic add with exact latency; a late kill during EXEC is ignored
    do_issue("add", 32'h0000_028B, 4'd3, 32'd7, 32'd9, 32'd0, 1'b1, 1'b1);
    do_commit(4'd3, 1'b0);
    commit_valid = 1'b1; commit_id = 4'd3; commit_kill = 1'b1;
    step();
    commit_valid = 1'b0; commit_kill = 1'b0;
    chk("lat_e1", 32'(result_valid), 32'd0);
    step();
    chk("lat_e2", 32'(result_valid), 32'd0);
    step();
    chk("lat_e3", 32'(result_valid), 32'd1);
    wait_result("add_res", 4'd3, 32'd16, 5'd5, 1'b1);
    chk("add_done_valid", 32'(result_valid), 32'd0);
    chk("add_done_busy", 32'(busy), 32'd0);

    // Wrapping sub (rd=0 -> no writeback) and add3
    do_issue("sub", mk(7'h0B, 3'b001, 5'd0), 4'd4, 32'd0, 32'd1, 32'd0, 1'b1, 1'b0);
    do_issue("add3", mk(7'h0B, 3'b100, 5'd7), 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd2, 1'b1, 1'b1);
    do_commit(4'd4, 1'b0);
    do_commit(4'd5, 1'b0);
    wait_result("sub_res", 4'd4, 32'hFFFF_FFFF, 5'd0, 1'b0);
    wait_result("add3_res", 4'd5, 32'd2, 5'd7, 1'b1);

    // Unclaimed opcode, then add3 waiting for rs3
    do_issue("uncl", mk(7'h33, 3'b000, 5'd1), 4'd6, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    chk("uncl_busy", 32'(busy), 32'd0);
    issue_instr = mk(7'h0B, 3'b100, 5'd2); issue_id = 4'd6;
    issue_rs_valid = 3'b011; issue_valid = 1'b1;
    #1;
    chk("rs3_wait_ready", 32'(issue_ready), 32'd0);
    chk("rs3_wait_accept", 32'(issue_accept), 32'd0);
    step();
    chk("rs3_wait_ready2", 32'(issue_ready), 32'd0);
    issue_valid = 1'b0;
    do_issue("rs3_ok", mk(7'h0B, 3'b100, 5'd2), 4'd6, 32'd1, 32'd1, 32'd1, 1'b1, 1'b1);
    do_commit(4'd6, 1'b1);
    step(); step();
    chk("kill6_busy", 32'(busy), 32'd0);
    chk("kill6_rvalid", 32'(result_valid), 32'd0);

    // Fill the FIFO; out-of-order commit still yields in-order results
    for (int i = 0; i < 4; i++)
      do_issue("fill", mk(7'h0B, 3'b000, 5'd1), 4'(i), 32'(i), 32'd10, 32'd0, 1'b1, 1'b1);
    issue_instr = mk(7'h0B, 3'b000, 5'd1); issue_id = 4'd4; issue_valid = 1'b1;
    #1;
    chk("full_ready", 32'(issue_ready), 32'd0);
    chk("full_accept", 32'(issue_accept), 32'd0);
    issue_valid = 1'b0;
    do_commit(4'd1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ooo_hold", 32'(result_valid), 32'd0);
    end
    do_commit(4'd0, 1'b0);
    wait_result("ooo_r0", 4'd0, 32'd10, 5'd1, 1'b1);
    wait_result("ooo_r1", 4'd1, 32'd11, 5'd1, 1'b1);
    do_commit(4'd2, 1'b1);
    do_commit(4'd3, 1'b1);
    step(); step(); step();
    chk("drain_busy", 32'(busy), 32'd0);

    // Kill head, same-cycle issue+commit for the second, backpressured result
    do_issue("k_i0", mk(7'h0B, 3'b000, 5'd8), 4'd0, 32'd100, 32'd200, 32'd0, 1'b1, 1'b1);
    commit_valid = 1'b1; commit_id = 4'd1; commit_kill = 1'b0;
    do_issue("k_i1", mk(7'h0B, 3'b001, 5'd9), 4'd1, 32'd50, 32'd20, 32'd0, 1'b1, 1'b1);
    commit_valid = 1'b0;
    result_ready = 1'b0;
    do_commit(4'd0, 1'b1);
    wait_result("bp_res", 4'd1, 32'd30, 5'd9, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(result_valid), 32'd1);
      chk("bp_data", result_data, 32'd30);
      chk("bp_id", 32'(result_id), 32'd1);
    end
    result_ready = 1'b1;
    step();
    chk("bp_drop", 32'(result_valid), 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("bp_no_extra", 32'(result_valid), 32'd0);
    chk("bp_busy", 32'(busy), 32'd0);

    // Reset while executing with three entries queued
    for (int i = 0; i < 3; i++)
      do_issue("rq", mk(7'h0B, 3'b000, 5'd3), 4'(i), 32'd1, 32'd1, 32'd0, 1'b1, 1'b1);
    do_commit(4'd0, 1'b0);
    step();
    chk("rq_exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rq_rst_ready", 32'(issue_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rq_rvalid", 32'(result_valid), 32'd0);
    chk("rq_busy", 32'(busy), 32'd0);
    chk("rq_ready", 32'(issue_ready), 32'd1);
    do_commit(4'd1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rq_stale", 32'(result_valid), 32'd0);
    end
    chk("rq_final_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/isolde_xif_coproc_responder.md
Name: isolde_xif_coproc_responder

Overview:
Coprocessor-side endpoint of the CV-X-IF issue/commit/result protocol. It answers issue requests from the core with accept/writeback, buffers accepted offloads until the core commits or kills them, and executes committed ops with a fixed latency. It then returns results on the result channel. It acts as a small ALU-style accelerator and is the bring-up target for the ISOLDE exec block's issue path.

Parameters:
- FifoDepth, 4: number of outstanding accepted instructions (power of 2, >=2).
- IdWidth, 4: width of the X-IF instruction id.
- Latency, 2: execution cycles per op (>=1).
- OpcodeMatch, 7'h0B: instr[6:0] value this block claims (custom-0).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- issue_valid_i  in  1  issue request valid.
- issue_ready_o  out  1  issue request can complete this cycle.
- issue_instr_i  in  32  offloaded instruction.
- issue_id_i  in  IdWidth  instruction id.
- issue_rs_i  in  96  {rs3,rs2,rs1} operand values, rs1 in [31:0].
- issue_rs_valid_i  in  3  per-operand valid.
- issue_accept_o  out  1  instruction claimed (valid during the issue handshake).
- issue_writeback_o  out  1  a result will be written to rd.
- commit_valid_i  in  1  commit transaction valid.
- commit_id_i  in  IdWidth  id being committed/killed.
- commit_kill_i  in  1  1 = kill, 0 = commit.
- result_valid_o  out  1  result valid.
- result_ready_i  in  1  core accepts result.
- result_id_o  out  IdWidth  id of result.
- result_data_o  out  32  result value.
- result_rd_o  out  5  destination register.
- result_we_o  out  1  write enable, equals entry's writeback.
- busy_o  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - rst_i high at a clk_i edge empties the FIFO and sets the FSM to IDLE.
  - During and after reset: issue_ready_o=0 (while rst_i is high), result_valid_o=0, result_* =0, busy_o=0.
  - Reset mid-operation drops all entries; no result is emitted for them.
- Decode (combinational on issue_instr_i):
  - Claimed iff opcode==OpcodeMatch and funct3 is in {000 add, 001 sub, 010 xor, 100 add3}.
  - Required operands: rs1 and rs2 always; rs3 only for funct3=100.
- Ready: issue_ready_o = !full && (required rs_valid bits all 1).
  - Unclaimed instructions need no operands and are ready whenever !full.
  - A pop in the same cycle does not free a slot for issue.
- Issue handshake (issue_valid_i && issue_ready_o):
  - issue_accept_o=1 if claimed. An accepted entry is pushed with {id, funct3, operands, rd=instr[11:7], committed=0, killed=0}.
  - issue_writeback_o = accept && rd!=0.
  - Unclaimed: accept=0, writeback=0, nothing pushed.
  - issue_accept_o and issue_writeback_o are 0 outside a handshake.
- Commit:
  - On commit_valid_i, the entry whose id==commit_id_i gets committed=1, or killed=1 if commit_kill_i.
  - An unknown id is ignored.
  - If issue and commit for the same id coincide, the commit applies to the newly pushed entry.
  - Ids among live entries are unique (core guarantee).
- FSM IDLE/EXEC/RESULT, operating on the head entry:
  - IDLE: if head is killed, pop it and stay in IDLE (no result). If head is committed, go to EXEC and load the counter with Latency-1.
  - EXEC: decrement each cycle; at 0, compute the result, register it into result_*, and go to RESULT. Total time from IDLE exit to result_valid_o=1 is exactly Latency+1 edges.
  - RESULT: result_valid_o=1 and all result_* stay stable until result_ready_i. On handshake: pop, result_valid_o=0 next cycle, go to IDLE.
  - A kill that arrives for the head while in EXEC/RESULT is ignored; the op completes.
- Arithmetic: 32-bit, wraps modulo 2^32, no flags.
  - add: rs1+rs2.
  - sub: rs1-rs2.
  - xor: rs1^rs2.
  - add3: rs1+rs2+rs3.
- FIFO:
  - Pointers wrap modulo FifoDepth.
  - full when count==FifoDepth; count never exceeds it.
  - Results return in issue order.

Test Plan:
- Issue add (instr 0x0000_028B, rd=5, id=3, rs1=7, rs2=9), commit id 3 -> accept=1, writeback=1. With result_ready_i=1, result_valid_o rises 3 cycles after commit, carrying id=3, data=16, rd=5, we=1.
- sub rs1=0, rs2=1 and add3 rs=FFFF_FFFF,1,2 -> results FFFF_FFFF and 2 (wrap).
- Issue opcode 0x33 -> accept=0 and FIFO count unchanged. Issue add3 with rs_valid=3'b011 -> issue_ready_o=0 until bit2 is set.
- Issue 4 ops with ids 0-3, no commit -> 5th issue sees issue_ready_o=0. Commit id 1 before id 0 -> no result until id 0 is committed; results then arrive in order 0,1.
- Issue ids 0,1; kill 0, commit 1 -> exactly one result (id 1). Hold result_ready_i=0 for 5 cycles -> result_* stable throughout.
- Assert rst_i during EXEC with 3 entries queued -> next cycle result_valid_o=0, busy_o=0, issue_ready_o=1; no stale result afterwards.
